// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^N) matrix-by-vector sequencer.
//   state_t        : sequencer states (LOAD, COMPUTE, EMIT)
//   AES_POLY       : default AES field polynomial x^8+x^4+x^3+x+1
//   LOAD_WORDS     : operand words per job for the default 4x4 geometry
//   load_words()   : operand words per job for any geometry
//   idx_w()        : counter width able to index 0..n-1 (never below 1 bit)
package gf_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam int DEF_N     = 8;
  localparam int DEF_ROW_A = 4;
  localparam int DEF_COL_A = 4;

  localparam logic [8:0] AES_POLY = 9'h11B;

  localparam int LOAD_WORDS = DEF_ROW_A * DEF_COL_A + DEF_COL_A;

  // A is stored row-major first, followed by b.
  function automatic int load_words(input int rows, input int cols);
    return rows * cols + cols;
  endfunction

  // Degenerate sizes (1 or 2 entries) still get a 1-bit counter.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gf_mac_step.sv
// One GF(2^N) multiply-accumulate step, purely combinational:
//   acc_out = acc_in XOR (a * b mod p)
// Ports:
//   p       in  N+1  field polynomial (bit N must be set)
//   a, b    in  N    factors
//   acc_in  in  N    running sum
//   acc_out out N    updated sum
module gf_mac_step #(
  parameter int N = 8
) (
  input  logic [N:0]   p,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] acc_in,
  output logic [N-1:0] acc_out
);

  // MSB-first shift-and-add; reduction is folded into every shift so the
  // partial product never exceeds N+1 bits.
  function automatic logic [N-1:0] galois_multiplication(
    input logic [N-1:0] x,
    input logic [N-1:0] y,
    input logic [N:0]   poly
  );
    logic [N:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      r = {r[N-1:0], 1'b0};
      if (r[N]) r = r ^ poly;
      if (y[i]) r = r ^ {1'b0, x};
    end
    return r[N-1:0];
  endfunction

  function automatic logic [N-1:0] galois_adder(
    input logic [N-1:0] x,
    input logic [N-1:0] y
  );
    return x ^ y;
  endfunction

  assign acc_out = galois_adder(acc_in, galois_multiplication(a, b, p));

endmodule

// File: rtl/gf_matvec_sequencer.sv
// Sequential GF(2^N) matrix-by-vector engine: s = A * b.
// A single shared MAC step is time-multiplexed across all terms.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   p          in   N+1  field polynomial, captured with the first word of a job
//   in_valid   in   load word valid
//   in_ready   out  load word accepted when in_valid && in_ready
//   in_data    in   N    A elements (row-major) then b elements
//   out_valid  out  result word valid
//   out_ready  in   consumer ready
//   out_data   out  N    s[row]
//   out_last   out  high with the final row's result
//   busy       out  low only when idle in LOAD with nothing loaded
module gf_matvec_sequencer
  import gf_pkg::*;
#(
  parameter int N     = 8,
  parameter int ROW_A = 4,
  parameter int COL_A = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N:0]   p,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int JOB_WORDS = load_words(ROW_A, COL_A);
  localparam int A_WORDS   = ROW_A * COL_A;
  localparam int LW        = idx_w(JOB_WORDS);
  localparam int RW        = idx_w(ROW_A);
  localparam int KW        = idx_w(COL_A);

  localparam logic [LW-1:0] LAST_WORD = LW'(JOB_WORDS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROW_A - 1);
  localparam logic [KW-1:0] LAST_K    = KW'(COL_A - 1);

  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          ready_q;

  logic [N-1:0]  opnd [JOB_WORDS];
  logic [N:0]    p_q;

  logic          load_hs;
  logic [LW-1:0] a_idx;
  logic [LW-1:0] b_idx;
  logic [N-1:0]  a_op;
  logic [N-1:0]  b_op;
  logic [N-1:0]  mac_out;

  // ready_q holds in_ready low until the first edge after reset release.
  assign in_ready  = ready_q && (state_q == LOAD);
  assign load_hs   = in_valid && in_ready;
  assign out_valid = (state_q == EMIT);
  assign out_data  = out_valid ? acc_q : '0;
  assign out_last  = out_valid && (row_q == LAST_ROW);
  assign busy      = !((state_q == LOAD) && (cnt_q == '0));

  // ---- operand fetch: A[row][k] and b[k] ----
  assign a_idx = LW'(row_q) * LW'(COL_A) + LW'(k_q);
  assign b_idx = LW'(A_WORDS) + LW'(k_q);
  assign a_op  = opnd[a_idx];
  assign b_op  = opnd[b_idx];

  gf_mac_step #(
    .N(N)
  ) u_mac (
    .p      (p_q),
    .a      (a_op),
    .b      (b_op),
    .acc_in (acc_q),
    .acc_out(mac_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    k_d     = k_q;
    acc_d   = acc_q;
    case (state_q)
      LOAD: begin
        if (load_hs) begin
          if (cnt_q == LAST_WORD) begin
            state_d = COMPUTE;
            cnt_d   = '0;
            row_d   = '0;
            k_d     = '0;
            acc_d   = '0;
          end else begin
            cnt_d = cnt_q + LW'(1);
          end
        end
      end
      COMPUTE: begin
        acc_d = mac_out;
        if (k_q == LAST_K) begin
          k_d     = '0;
          state_d = EMIT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      EMIT: begin
        // acc_q is held while the consumer stalls.
        if (out_ready) begin
          acc_d = '0;
          k_d   = '0;
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            row_d   = row_q + RW'(1);
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      row_q   <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      ready_q <= 1'b1;
    end
  end

  // Operand storage carries no reset; a new job always overwrites every word
  // before COMPUTE reads it.
  always_ff @(posedge clk) begin
    if (load_hs) begin
      opnd[cnt_q] <= in_data;
      if (cnt_q == '0) p_q <= p;
    end
  end

endmodule

// File: tb/tb_gf_matvec_sequencer.sv
module tb_gf_matvec_sequencer;
  import gf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic [8:0] p;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_last, busy;

  logic [8:0] p1;
  logic       in_valid1, in_ready1;
  logic [7:0] in_data1;
  logic       out_valid1, out_ready1;
  logic [7:0] out_data1;
  logic       out_last1, busy1;

  gf_matvec_sequencer #(.N(8), .ROW_A(4), .COL_A(4)) dut (
    .clk(clk), .rst_n(rst_n), .p(p),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  gf_matvec_sequencer #(.N(8), .ROW_A(1), .COL_A(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .p(p1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_last(out_last1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  typedef struct {
    logic [15:0][7:0] a;
    logic [3:0][7:0]  b;
    logic [8:0]       p;
    logic [3:0][7:0]  s;
  } vec_t;

  exp_t sbq[$];
  int   pop_cyc[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   pops  = 0;
  logic acc_flag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // LSB-first reference multiply (a doubled each step).
  function automatic logic [7:0] mdl_mul(input logic [7:0] a, input logic [7:0] b,
                                         input logic [8:0] pp);
    logic [7:0] x, r;
    x = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ pp[7:0]) : {x[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0][7:0] mk16(input logic [127:0] v);
    logic [15:0][7:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [3:0][7:0] mk4(input logic [31:0] v);
    logic [3:0][7:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[31-8*i -: 8];
    return r;
  endfunction

  // One clock: scoreboard check on the values about to be sampled, then edge.
  task automatic cycle();
    exp_t e;
    acc_flag = in_valid && in_ready;
    if (out_valid) begin
      if (sbq.size() == 0) begin
        chk("out_with_empty_scoreboard", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq[0];
        chk("out_data", out_data, e.d);
        chk("out_last", out_last, e.l);
        chk("in_ready_while_out", in_ready, 0);
        if (out_ready) begin
          void'(sbq.pop_front());
          pops++;
          pop_cyc.push_back(cyc);
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [3:0][7:0] s);
    exp_t e;
    for (int r = 0; r < 4; r++) begin
      e.d = s[r];
      e.l = (r == 3);
      sbq.push_back(e);
    end
  endtask

  task automatic load_job(input logic [15:0][7:0] a, input logic [3:0][7:0] b,
                          input logic [8:0] pp, input bit gaps, input bit pswitch);
    p = pp;
    for (int w = 0; w < 20; w++) begin
      int guard;
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          cycle();
        end
      end
      in_valid = 1'b1;
      in_data  = (w < 16) ? a[w] : b[w-16];
      guard    = 0;
      acc_flag = 1'b0;
      while (!acc_flag && guard < 100) begin
        cycle();
        guard++;
      end
      chk("load_accept", acc_flag, 1);
      if (pswitch && w == 0) p = 9'h11D;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_ready);
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 400) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      n++;
    end
    out_ready = 1'b1;
    chk("drain_scoreboard_empty", 32'(sbq.size()), 0);
    chk("drain_idle_busy", busy, 0);
  endtask

  task automatic wait_valid(input int expect_n, input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      cycle();
      n++;
    end
    chk(nm, n, expect_n);
  endtask

  task automatic wait_pops(input int start, input int target);
    int n;
    n = 0;
    while (pops - start < target && n < 100) begin
      cycle();
      n++;
    end
    chk("wait_pops", pops - start, target);
  endtask

  vec_t tbl[6];
  logic [7:0] m1[4][3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   start;

    tbl[0].a = mk16(128'h01000000_00010000_00000100_00000001);
    tbl[0].b = mk4(32'h01020304); tbl[0].p = AES_POLY; tbl[0].s = mk4(32'h01020304);
    tbl[1].a = mk16(128'h02030101_01020301_01010203_03010102);
    tbl[1].b = mk4(32'hDB135345); tbl[1].p = AES_POLY; tbl[1].s = mk4(32'h8E4DA1BC);
    tbl[2].a = mk16(128'h0);
    tbl[2].b = mk4(32'hDB135345); tbl[2].p = AES_POLY; tbl[2].s = mk4(32'h00000000);
    tbl[3].a = mk16({16{8'h01}});
    tbl[3].b = mk4(32'h01020408); tbl[3].p = AES_POLY; tbl[3].s = mk4(32'h0F0F0F0F);
    tbl[4].a = mk16(128'h02000000_00020000_00000200_00000002);
    tbl[4].b = mk4(32'h804001FF); tbl[4].p = 9'h11D;   tbl[4].s = mk4(32'h1D8002E3);
    tbl[5].a = mk16(128'h02000000_00020000_00000200_00000002);
    tbl[5].b = mk4(32'h80C003FF); tbl[5].p = AES_POLY; tbl[5].s = mk4(32'h1B9B06E5);

    m1[0] = '{8'h53, 8'hCA, 8'h01};
    m1[1] = '{8'h00, 8'hCA, 8'h00};
    m1[2] = '{8'h01, 8'hB7, 8'hB7};
    m1[3] = '{8'h57, 8'h83, 8'hC1};

    p = AES_POLY; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    p1 = AES_POLY; in_valid1 = 1'b0; in_data1 = 8'h00; out_ready1 = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready1", in_ready1, 0);
    rst_n = 1'b1;
    cycle();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_in_ready1", in_ready1, 1);

    // 1x1 geometry: single multiply per job
    for (int i = 0; i < 4; i++) begin
      in_valid1 = 1'b1;
      in_data1  = m1[i][0];
      chk("m1_ready_a", in_ready1, 1);
      cycle();
      chk("m1_busy_after_a", busy1, 1);
      in_data1 = m1[i][1];
      chk("m1_ready_b", in_ready1, 1);
      cycle();
      in_valid1 = 1'b0;
      chk("m1_in_ready_compute", in_ready1, 0);
      chk("m1_valid_early", out_valid1, 0);
      cycle();
      chk("m1_out_valid", out_valid1, 1);
      chk("m1_out_data", out_data1, m1[i][2]);
      chk("m1_out_last", out_last1, 1);
      cycle();
      chk("m1_back_idle_valid", out_valid1, 0);
      chk("m1_back_idle_busy", busy1, 0);
    end

    // Table-driven 4x4 jobs with latency and row period checks
    for (int t = 0; t < 6; t++) begin
      v = tbl[t];
      pop_cyc.delete();
      push_exp(v.s);
      load_job(v.a, v.b, v.p, 1'b0, 1'b0);
      chk("busy_after_load", busy, 1);
      wait_valid(4, "latency_to_first_valid");
      drain(1'b0);
      chk("row_count", 32'(pop_cyc.size()), 4);
      for (int r = 1; r < pop_cyc.size(); r++)
        chk("row_period", pop_cyc[r] - pop_cyc[r-1], 5);
    end

    // Backpressure on row 1
    push_exp(tbl[1].s);
    load_job(tbl[1].a, tbl[1].b, AES_POLY, 1'b0, 1'b0);
    start = pops;
    out_ready = 1'b1;
    wait_pops(start, 1);
    out_ready = 1'b0;
    wait_valid(4, "bp_row1_latency");
    for (int i = 0; i < 7; i++) cycle();
    chk("bp_hold_data", out_data, 8'h4D);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_no_extra_pop", pops - start, 1);
    drain(1'b0);
    chk("bp_total_pops", pops - start, 4);

    // Load gaps with p switched after the first word
    push_exp(tbl[1].s);
    load_job(tbl[1].a, tbl[1].b, AES_POLY, 1'b1, 1'b1);
    drain(1'b0);
    p = AES_POLY;

    // Random jobs against the model, with random output backpressure
    for (int j = 0; j < 4; j++) begin
      logic [15:0][7:0] ra;
      logic [3:0][7:0]  rb, rs;
      logic [8:0]       rp;
      rp = (j % 2 == 0) ? 9'h11B : 9'h11D;
      for (int i = 0; i < 16; i++) ra[i] = 8'($urandom);
      for (int i = 0; i < 4; i++)  rb[i] = 8'($urandom);
      for (int r = 0; r < 4; r++) begin
        rs[r] = 8'h00;
        for (int k = 0; k < 4; k++) rs[r] = rs[r] ^ mdl_mul(ra[r*4+k], rb[k], rp);
      end
      push_exp(rs);
      load_job(ra, rb, rp, j[0], 1'b0);
      drain(1'b1);
    end

    // Reset in the middle of row 2's accumulation
    push_exp(tbl[1].s);
    load_job(tbl[1].a, tbl[1].b, AES_POLY, 1'b0, 1'b0);
    start = pops;
    wait_pops(start, 2);
    cycle();
    cycle();
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_data", out_data, 0);
    sbq.delete();
    @(negedge clk);
    cycle();
    chk("abort_next_out_valid", out_valid, 0);
    chk("abort_next_busy", busy, 0);
    rst_n = 1'b1;
    cycle();
    chk("abort_release_in_ready", in_ready, 1);
    push_exp(tbl[1].s);
    load_job(tbl[1].a, tbl[1].b, AES_POLY, 1'b0, 1'b0);
    wait_valid(4, "fresh_job_latency");
    drain(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
